// File: rtl/mips_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : mips_hilo_muldiv
// Description : Iterative multiply/divide unit owning the MIPS HI/LO registers.
//               MULT/MULTU use shift-add and DIV/DIVU use restoring division.
//               Both work on operand magnitudes, one bit per cycle, followed
//               by a single sign-fixup/write-back cycle. MTHI/MTLO writes are
//               accepted only while idle.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               start, op       - launch request and opcode (00 MULT, 01 MULTU,
//                                 10 DIV, 11 DIVU)
//               srca, srcb      - rs/rt operands (srca is also MTHI/MTLO data)
//               hi_write/lo_write, hi_select/lo_select - move-to controls
//               hi, lo          - architectural HI/LO registers
//               busy            - operation in flight
//               done            - one-cycle pulse when HI/LO take a new result
// Revision    : 1.0 - initial release
// ============================================================================
module mips_hilo_muldiv #(
   parameter int DATA_WIDTH      = 32,
   parameter int CNT_WIDTH       = 6,
   parameter int HI_LO_SEL_WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [1:0]                 op,
   input  logic [DATA_WIDTH-1:0]      srca,
   input  logic [DATA_WIDTH-1:0]      srcb,
   input  logic                       hi_write,
   input  logic                       lo_write,
   input  logic [HI_LO_SEL_WIDTH-1:0] hi_select,
   input  logic [HI_LO_SEL_WIDTH-1:0] lo_select,
   output logic [DATA_WIDTH-1:0]      hi,
   output logic [DATA_WIDTH-1:0]      lo,
   output logic                       busy,
   output logic                       done
);

   localparam int                       c_w      = DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0]     c_last   = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [HI_LO_SEL_WIDTH-1:0] c_sel_src = HI_LO_SEL_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2
   } state_t;

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [c_w-1:0]       r_a;         // multiplicand / dividend (shifted out MSB-first)
   logic [c_w-1:0]       r_b;         // multiplier (shifted out LSB-first) / divisor
   logic [2*c_w-1:0]     r_acc;       // mul: product; div: {remainder, quotient}
   logic                 r_is_div;
   logic                 r_neg_q;     // product / quotient sign
   logic                 r_neg_r;     // remainder sign
   logic                 r_div_zero;
   logic [c_w-1:0]       r_srca_raw;  // original dividend for divide-by-zero HI
   logic [c_w-1:0]       r_hi;
   logic [c_w-1:0]       r_lo;
   logic                 r_done;

   // Operand magnitudes and signs at launch (op[0] = 0 means signed)
   logic           w_signed;
   logic           w_sa;
   logic           w_sb;
   logic [c_w-1:0] w_mag_a;
   logic [c_w-1:0] w_mag_b;

   assign w_signed = ~op[0];
   assign w_sa     = w_signed & srca[c_w-1];
   assign w_sb     = w_signed & srcb[c_w-1];
   // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
   assign w_mag_a  = w_sa ? -srca : srca;
   assign w_mag_b  = w_sb ? -srcb : srcb;

   // Shift-add step: add multiplicand to upper half, then shift right
   logic [c_w:0]   w_mul_sum;
   assign w_mul_sum = {1'b0, r_acc[2*c_w-1:c_w]} + {1'b0, (r_b[0] ? r_a : {c_w{1'b0}})};

   // Restoring divide step: bring in next dividend bit, try subtracting divisor.
   // A borrow shows up in bit c_w because the partial remainder is < 2*divisor.
   logic [c_w:0]   w_rem_shift;
   logic [c_w:0]   w_trial;
   logic           w_q_bit;
   logic [c_w-1:0] w_rem_next;
   assign w_rem_shift = {r_acc[2*c_w-1:c_w], r_a[c_w-1]};
   assign w_trial     = w_rem_shift - {1'b0, r_b};
   assign w_q_bit     = ~w_trial[c_w];
   assign w_rem_next  = w_q_bit ? w_trial[c_w-1:0] : w_rem_shift[c_w-1:0];

   // Sign fixup of the magnitude results
   logic [2*c_w-1:0] w_prod;
   logic [c_w-1:0]   w_quo;
   logic [c_w-1:0]   w_rem;
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[c_w-1:0] : r_acc[c_w-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*c_w-1:c_w] : r_acc[2*c_w-1:c_w];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_srca_raw <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  // A move-to write in the same cycle is dropped
                  r_a        <= w_mag_a;
                  r_b        <= w_mag_b;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_is_div   <= op[1];
                  r_neg_q    <= w_sa ^ w_sb;
                  r_neg_r    <= w_sa;
                  r_div_zero <= (srcb == '0);
                  r_srca_raw <= srca;
                  r_state    <= CALC;
               end else begin
                  if (hi_write && (hi_select == c_sel_src)) r_hi <= srca;
                  if (lo_write && (lo_select == c_sel_src)) r_lo <= srca;
               end
            end
            CALC: begin
               if (r_is_div) begin
                  r_acc <= {w_rem_next, r_acc[c_w-2:0], w_q_bit};
                  r_a   <= r_a << 1;
               end else begin
                  r_acc <= {w_mul_sum, r_acc[c_w-1:1]};
                  r_b   <= r_b >> 1;
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last) r_state <= FIXUP;
            end
            FIXUP: begin
               if (r_is_div) begin
                  if (r_div_zero) begin
                     r_lo <= '1;
                     r_hi <= r_srca_raw;
                  end else begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign done = r_done;
   assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mips_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_hilo_muldiv
// Description : Self-checking bench for mips_hilo_muldiv. Expected HI/LO pairs
//               are queued at launch and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_hilo_muldiv;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        hi_write;
   logic        lo_write;
   logic [1:0]  hi_select;
   logic [1:0]  lo_select;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int          n_cmp;
   int          n_err;
   logic [63:0] sb_q[$];

   mips_hilo_muldiv #(
      .DATA_WIDTH     (32),
      .CNT_WIDTH      (6),
      .HI_LO_SEL_WIDTH(2)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .srca     (srca),
      .srcb     (srcb),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .hi_select(hi_select),
      .lo_select(lo_select),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model using native 64-bit arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sbv;
      longint      q;
      longint      r;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] uq;
      logic [63:0] ur;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (o)
         2'b00: begin
            q = sa * sbv;
            return q;
         end
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q  = sa / sbv;
            r  = sa % sbv;
            uq = q;
            ur = r;
            return {ur[31:0], uq[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   // Scoreboard: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check_value("unexpected_done", 64'd1, 64'd0);
         end else begin
            check_value("hilo_result", {hi, lo}, sb_q.pop_front());
         end
      end
   end

   // Drive one start cycle; returns #1 into cycle 1
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
      @(posedge clk); #1;
      start = 1'b1; op = o; srca = a; srcb = b;
      sb_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      srca  = $urandom;
      srcb  = $urandom;
   endtask

   // Wait (bounded) for done; n0 is the cycle index we are currently in
   task automatic wait_done(input int n0);
      int n;
      bit got;
      bit busy_ok;
      n       = n0;
      got     = 1'b0;
      busy_ok = 1'b1;
      while (n < 60 && !got) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
         end else begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
         end
      end
      check_value("done_seen", 64'(got), 64'd1);
      check_value("done_cycle", 64'(n), 64'd34);
      check_value("busy_during_op", 64'(busy_ok), 64'd1);
      check_value("busy_at_done", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check_value("done_one_cycle", 64'(done), 64'd0);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
      launch(o, a, b, exp);
      wait_done(1);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
      hi_write = 1'b0; lo_write = 1'b0; hi_select = 2'b00; lo_select = 2'b00;

      repeat (3) @(posedge clk);
      #1;
      check_value("reset_hi", 64'(hi), 64'd0);
      check_value("reset_lo", 64'(lo), 64'd0);
      check_value("reset_busy", 64'(busy), 64'd0);
      check_value("reset_done", 64'(done), 64'd0);
      rst_n = 1'b1;

      // Directed multiply/divide cases
      run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run_op(2'b11, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF);
      run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF);

      // Randomised operands against the reference model
      for (int i = 0; i < 6; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (i[0]) rb = rb >> 20;
         run_op(ro, ra, rb, model(ro, ra, rb));
      end

      // Move-to writes in IDLE
      @(posedge clk); #1;
      hi_write = 1'b1; hi_select = 2'b01; srca = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      hi_write = 1'b0; lo_write = 1'b1; lo_select = 2'b01; srca = 32'h5A5A_5A5A;
      @(posedge clk); #1;
      lo_write = 1'b0;
      check_value("mthi", 64'(hi), 64'hA5A5_A5A5);
      check_value("mtlo", 64'(lo), 64'h5A5A_5A5A);
      hi_write = 1'b1; hi_select = 2'b10; lo_write = 1'b1; lo_select = 2'b00; srca = 32'hFFFF_0000;
      @(posedge clk); #1;
      check_value("mthi_badsel", 64'(hi), 64'hA5A5_A5A5);
      check_value("mtlo_badsel", 64'(lo), 64'h5A5A_5A5A);
      hi_select = 2'b01; lo_select = 2'b01; srca = 32'h1234_5678;
      @(posedge clk); #1;
      hi_write = 1'b0; lo_write = 1'b0;
      check_value("mthi_both", 64'(hi), 64'h1234_5678);
      check_value("mtlo_both", 64'(lo), 64'h1234_5678);

      // start and hi_write together: start wins
      @(posedge clk); #1;
      start = 1'b1; op = 2'b11; srca = 32'd7; srcb = 32'd2; hi_write = 1'b1; hi_select = 2'b01;
      sb_q.push_back(64'h0000_0001_0000_0003);
      @(posedge clk); #1;
      start = 1'b0; hi_write = 1'b0;
      check_value("start_beats_mthi", 64'(hi), 64'h1234_5678);
      wait_done(1);

      // Move-to writes and a second start while busy are ignored
      launch(2'b01, 32'd2, 32'd3, 64'd6);
      hi_write = 1'b1; lo_write = 1'b1; hi_select = 2'b01; lo_select = 2'b01;
      srca = 32'hDEAD_BEEF; start = 1'b1; op = 2'b00;
      repeat (9) @(posedge clk);
      #1;
      check_value("busy_hold_hi", 64'(hi), 64'd1);
      check_value("busy_hold_lo", 64'(lo), 64'd3);
      hi_write = 1'b0; lo_write = 1'b0; start = 1'b0;
      wait_done(10);

      // Reset mid-operation: no partial write, no done
      @(posedge clk); #1;
      start = 1'b1; op = 2'b01; srca = 32'd3; srcb = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_value("midrst_hi", 64'(hi), 64'd0);
      check_value("midrst_lo", 64'(lo), 64'd0);
      check_value("midrst_busy", 64'(busy), 64'd0);
      check_value("midrst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_value("post_rst_hi", 64'(hi), 64'd0);
      check_value("post_rst_lo", 64'(lo), 64'd0);
      run_op(2'b01, 32'd3, 32'd4, 64'd12);

      repeat (5) @(posedge clk);
      #1;
      check_value("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_hilo_muldiv.md
Name: mips_hilo_muldiv

Overview:
- Iterative multiply/divide unit that owns the architectural HI and LO registers.
- It consumes the HI/LO write controls from the controller (hi_write, lo_write, hi_select, lo_select) for MTHI/MTLO.
- It executes MULT/MULTU/DIV/DIVU over multiple cycles and exposes HI/LO to the register-write mux for MFHI/MFLO.
- It raises busy so the datapath stalls while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width
CNT_WIDTH, 6, iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  core clock
rst_n  input  1  reset; asynchronous, active-low
start  input  1  launch mul/div this cycle (honoured only when idle)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  input  DATA_WIDTH  rs operand: multiplicand/dividend; also MTHI/MTLO source
srcb  input  DATA_WIDTH  rt operand: multiplier/divisor
hi_write  input  1  write HI from a move-to source
lo_write  input  1  write LO from a move-to source
hi_select  input  HI_LO_SEL_WIDTH  HI write source; 01 = srca, all other codes write nothing
lo_select  input  HI_LO_SEL_WIDTH  LO write source; 01 = srca, all other codes write nothing
hi  output  DATA_WIDTH  current HI register
lo  output  DATA_WIDTH  current LO register
busy  output  1  operation in flight (state != IDLE)
done  output  1  one-cycle pulse when HI/LO take a new mul/div result

Behaviour:
- Reset (async, rst_n low):
  - hi = 0, lo = 0, busy = 0, done = 0, state = IDLE, counter = 0.
  - All internal accumulators are cleared.
- State machine: IDLE -> CALC -> FIXUP -> IDLE.
- IDLE:
  - start = 1: latch |srca| and |srcb| (absolute value for signed ops, raw for unsigned). Latch result signs: product/quotient sign = sa^sb, remainder sign = sa (signed ops only). Clear the 2*DATA_WIDTH accumulator, counter = 0, go to CALC.
  - Otherwise, apply move-to writes: hi_write & hi_select==01 -> hi <= srca; lo_write & lo_select==01 -> lo <= srca. HI and LO update independently in the same cycle.
  - start and a move-to write in the same cycle: start wins, the write is dropped.
- CALC: exactly DATA_WIDTH cycles, one bit per cycle, counter increments each cycle. After the cycle with counter == DATA_WIDTH-1, go to FIXUP.
  - Multiply: shift-add, unsigned, on magnitudes.
  - Divide: restoring, unsigned, on magnitudes.
- FIXUP (1 cycle):
  - Apply sign correction (two's complement negate where the latched sign is 1).
  - Write results: mult -> {hi,lo} = 64-bit product; div -> lo = quotient, hi = remainder.
  - Register done = 1 for the next cycle, go to IDLE.
- Latency:
  - start sampled at the end of cycle 0.
  - busy = 1 in cycles 1..DATA_WIDTH+1 (cycles 1..33 at default).
  - New hi/lo and done = 1 in cycle DATA_WIDTH+2 (cycle 34); busy = 0 in that cycle.
- Inputs ignored while busy:
  - start is ignored; no queueing, no restart.
  - hi_write/lo_write are ignored; the controller stalls on busy.
  - srca/srcb are not required to stay stable after the start cycle.
- hi/lo outputs are direct register outputs (no bypass). While busy they hold their pre-operation values and change only in the FIXUP write.
- Divide by zero (srcb == 0), signed and unsigned: lo = all-ones, hi = srca as latched at start (original signed value for DIV). Same latency, done pulses normally.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0, no exception.
- Most-negative operand: the magnitude of 0x80000000 is 0x80000000 as an unsigned value; no overflow in mult.
- Reset asserted mid-operation: immediately return to IDLE with hi = lo = 0, busy = 0, done = 0. No partial write.
- op values are all legal; there is no error output.

Test Plan:
- MULTU srca=0xFFFFFFFF, srcb=0x00000002 -> after 34 cycles hi=0x00000001, lo=0xFFFFFFFE, done pulse 1 cycle, busy high cycles 1..33.
- MULT srca=0xFFFFFFFD (-3), srcb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU srca=0x1234, srcb=0 -> lo=0xFFFFFFFF, hi=0x1234, done at cycle 34.
- Idle, hi_write=1, hi_select=01, srca=0xA5A5A5A5, then lo_write=1, lo_select=01, srca=0x5A5A5A5A -> hi=0xA5A5A5A5, lo=0x5A5A5A5A. Same writes issued while busy -> no change, result of the pending op is written. start + hi_write together in IDLE -> op launched, hi unchanged.
- start MULTU 3*4, assert rst_n low at cycle 10 -> hi=lo=0, busy=0, no done. Then start is issued again after release -> hi=0, lo=12 at cycle 34.
